path_replayer: RTL

Consumer for the maze solver's move list. After the solver has stored its route, this block reads the list one 2-bit move at a time through the list's `en_read`/`read_done` port and replays the route from cell (0,0). Each step is checked against the grid bounds and the maze wall memory. It reports the final coordinates, the step count, and whether the path is a legal route ending at (15,15).

---
 rtl/path_replayer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/path_replayer.sv
// Replays a stored maze route from (0,0): fetches one 2-bit move per step,
// bound-checks it, looks up the wall bit, and commits or flags an error.
module path_replayer #(
  parameter int N_BITS   = 4,
  parameter int CNT_BITS = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  output logic                  list_en_read,
  input  logic [1:0]            move_in,
  input  logic                  list_done,
  output logic                  maze_rd,
  output logic [2*N_BITS-1:0]   maze_addr,
  input  logic                  maze_data,
  output logic [N_BITS-1:0]     cur_x,
  output logic [N_BITS-1:0]     cur_y,
  output logic [CNT_BITS-1:0]   step_count,
  output logic                  busy,
  output logic                  done,
  output logic                  path_ok,
  output logic                  err_bound,
  output logic                  err_wall
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_MEM, S_DONE, S_ERR
  } state_t;

  localparam logic [N_BITS-1:0]   POS_MAX = '1;
  localparam logic [N_BITS-1:0]   POS_ONE = {{(N_BITS-1){1'b0}}, 1'b1};
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

  state_t state_reg, state_next;
  logic              at_bound;
  logic [N_BITS-1:0] step_x, step_y;
  logic              restart;

  // Bound check is decided from the current position, never from a wrapped sum.
  always_comb begin
    at_bound = 1'b0;
    step_x   = cur_x;
    step_y   = cur_y;
    case (move_in)
      2'b00: begin at_bound = (cur_x == POS_MAX); step_x = cur_x + POS_ONE; end
      2'b01: begin at_bound = (cur_y == POS_MAX); step_y = cur_y + POS_ONE; end
      2'b10: begin at_bound = (cur_x == '0);      step_x = cur_x - POS_ONE; end
      default: begin at_bound = (cur_y == '0);    step_y = cur_y - POS_ONE; end
    endcase
  end

  assign restart = start && (state_reg == S_IDLE || state_reg == S_DONE || state_reg == S_ERR);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_DONE, S_ERR: if (start) state_next = S_REQ;
      S_REQ:  state_next = S_WAIT;
      S_WAIT: begin
        if (list_done)     state_next = S_DONE;
        else if (at_bound) state_next = S_ERR;
        else               state_next = S_MEM;
      end
      S_MEM:  state_next = maze_data ? S_ERR : S_REQ;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg == S_REQ) || (state_reg == S_WAIT) || (state_reg == S_MEM);
    done = (state_reg == S_DONE);
  end

  // maze_addr doubles as the pending next position between WAIT and MEM.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      list_en_read <= 1'b0;
      maze_rd      <= 1'b0;
      maze_addr    <= '0;
      cur_x        <= '0;
      cur_y        <= '0;
      step_count   <= '0;
      path_ok      <= 1'b0;
      err_bound    <= 1'b0;
      err_wall     <= 1'b0;
    end else begin
      list_en_read <= (state_next == S_REQ);
      maze_rd      <= 1'b0;
      if (restart) begin
        cur_x      <= '0;
        cur_y      <= '0;
        step_count <= '0;
        path_ok    <= 1'b0;
        err_bound  <= 1'b0;
        err_wall   <= 1'b0;
      end
      case (state_reg)
        S_WAIT: begin
          if (list_done) begin
            path_ok <= (cur_x == POS_MAX) && (cur_y == POS_MAX);
          end else if (at_bound) begin
            err_bound <= 1'b1;
          end else begin
            maze_rd   <= 1'b1;
            maze_addr <= {step_y, step_x};
          end
        end
        S_MEM: begin
          if (maze_data) begin
            err_wall <= 1'b1;
          end else begin
            cur_x <= maze_addr[N_BITS-1:0];
            cur_y <= maze_addr[2*N_BITS-1:N_BITS];
            if (step_count != CNT_MAX) step_count <= step_count + CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
